// File: rtl/iic_slave_regfile.sv
// iic_slave_regfile: I2C target at DEV_ADDR fronting an 8-byte register file, regs 0..2 exposed as BCD time.
// Define IIC_SLAVE_AUTOINC_EN to advance the register pointer after every written or ACKed read byte.
module iic_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h68
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rtc_secd,
    output logic [7:0] rtc_mini,
    output logic [7:0] rtc_hour,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK} state_t;
    state_t state, state_n;
    logic [2:0] scl_q, sda_q, cnt, cnt_n, ptr, ptr_n, ptr_inc;
    logic [7:0] sr, sr_n, rx_byte;
    logic [7:0] regs [8];
    logic oe, oe_n, ack_on, ack_n, busy_n, we;
    logic scl_rise, scl_fall, start, stop;

`ifdef IIC_SLAVE_AUTOINC_EN
    assign ptr_inc = ptr + 3'd1;
`else
    assign ptr_inc = ptr;
`endif

    assign sda      = oe ? 1'b0 : 1'bz;
    assign rtc_secd = regs[0];
    assign rtc_mini = regs[1];
    assign rtc_hour = regs[2];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[1] & ~sda_q[2] & sda_q[1];
    assign rx_byte  = {sr[6:0], sda_q[1]};

    // ack_on marks that the ACK low is already on the bus; the next scl fall ends it
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sr_n = sr;
        oe_n = oe;
        ack_n = ack_on;
        ptr_n = ptr;
        busy_n = busy;
        we = 1'b0;
        if (start) begin
            state_n = ADDR;
            cnt_n = '0;
            oe_n = 1'b0;
            ack_n = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n = 1'b0;
            ack_n = 1'b0;
            busy_n = 1'b0;
        end else if (scl_rise) begin
            cnt_n = cnt + 3'd1;
            if (state inside {ADDR, PTR, WDATA})
                sr_n = rx_byte;
            if (state == RDATA_ACK) begin
                cnt_n = '0;
                state_n = sda_q[1] ? IDLE : RDATA;
                busy_n = ~sda_q[1];
                if (!sda_q[1]) begin
                    ptr_n = ptr_inc;
                    sr_n = regs[ptr_inc];
                end
            end else if (cnt == 3'd7) begin
                case (state)
                    ADDR: begin
                        state_n = rx_byte[7:1] == DEV_ADDR ? ADDR_ACK : IDLE;
                        busy_n = rx_byte[7:1] == DEV_ADDR;
                    end
                    PTR: begin
                        ptr_n = rx_byte[2:0];
                        state_n = PTR_ACK;
                    end
                    WDATA: begin
                        we = 1'b1;
                        ptr_n = ptr_inc;
                        state_n = WDATA_ACK;
                    end
                    RDATA: state_n = RDATA_ACK;
                    default: ;
                endcase
            end
        end else if (scl_fall) begin
            case (state)
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    oe_n = ~ack_on;
                    ack_n = ~ack_on;
                    if (ack_on) begin
                        cnt_n = '0;
                        state_n = state == ADDR_ACK ? (sr[0] ? RDATA : PTR) : WDATA;
                        if (state == ADDR_ACK && sr[0]) begin
                            oe_n = ~regs[ptr][7];
                            sr_n = {regs[ptr][6:0], 1'b0};
                        end
                    end
                end
                RDATA: begin
                    oe_n = ~sr[7];
                    sr_n = {sr[6:0], 1'b0};
                end
                RDATA_ACK: oe_n = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
            state <= IDLE;
            cnt <= '0;
            ptr <= '0;
            sr <= '0;
            oe <= 1'b0;
            ack_on <= 1'b0;
            busy <= 1'b0;
            wr_stb <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
            state <= state_n;
            cnt <= cnt_n;
            ptr <= ptr_n;
            sr <= sr_n;
            oe <= oe_n;
            ack_on <= ack_n;
            busy <= busy_n;
            wr_stb <= we;
            if (we) begin
                regs[ptr] <= rx_byte;
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
        end
    end
endmodule

// File: tb/tb_iic_slave_regfile.sv
// tb_iic_slave_regfile: bit-banged I2C master with randomized transfers, checked against a register-file model.
module tb_iic_slave_regfile;
    localparam int Q = 50;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
    wire sda;
    logic [7:0] rtc_secd, rtc_mini, rtc_hour, wr_data;
    logic [2:0] wr_addr;
    logic wr_stb, busy, busy_seen;
    int errors = 0, checks = 0, nacks;
    logic [7:0] mregs [8];
    logic [2:0] mptr;
    logic [10:0] exp_q[$], act_q[$];
    logic [7:0] wbuf[$], rbuf[$], ebuf[$];
`ifdef IIC_SLAVE_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);
    always #5 clk = ~clk;

    iic_slave_regfile dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .rtc_secd(rtc_secd), .rtc_mini(rtc_mini), .rtc_hour(rtc_hour),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always @(negedge clk) if (wr_stb) act_q.push_back({wr_addr, wr_data});

    function automatic void model_write(input logic [7:0] p);
        mptr = p[2:0];
        foreach (wbuf[i]) begin
            mregs[mptr] = wbuf[i];
            exp_q.push_back({mptr, wbuf[i]});
            if (AUTO) mptr = mptr + 3'd1;
        end
    endfunction

    function automatic void model_read(input logic [7:0] p, input int n_rd);
        mptr = p[2:0];
        ebuf = {};
        for (int i = 0; i < n_rd; i++) begin
            ebuf.push_back(mregs[mptr]);
            if (AUTO && i < n_rd - 1) mptr = mptr + 3'd1;
        end
    endfunction

    task automatic i2c_start;
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic i2c_wr(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; nack = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_rd(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; #Q; scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0; #Q;
        end
        m_sda = nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; m_sda = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] p);
        logic n;
        nacks = 0;
        i2c_start;
        i2c_wr(8'hD0, n); if (n) nacks++;
        busy_seen = busy;
        i2c_wr(p, n); if (n) nacks++;
        foreach (wbuf[i]) begin
            i2c_wr(wbuf[i], n); if (n) nacks++;
        end
        i2c_stop;
    endtask

    task automatic do_read(input logic [7:0] p, input int n_rd);
        logic n;
        logic [7:0] b;
        nacks = 0;
        rbuf = {};
        i2c_start;
        i2c_wr(8'hD0, n); if (n) nacks++;
        busy_seen = busy;
        i2c_wr(p, n); if (n) nacks++;
        i2c_start;
        i2c_wr(8'hD1, n); if (n) nacks++;
        for (int i = 0; i < n_rd; i++) begin
            i2c_rd(i == n_rd - 1, b);
            rbuf.push_back(b);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mptr = 3'd0;
        rst = 1'b1; #(4*Q);
        checks++; if ({rtc_secd, rtc_mini, rtc_hour} !== 24'h0) begin errors++; $display("FAIL reset_rtc: got %h want 000000", {rtc_secd, rtc_mini, rtc_hour}); end
        checks++; if ({wr_stb, wr_addr, wr_data, busy} !== 13'h0) begin errors++; $display("FAIL reset_outs: got %h want 0000", {wr_stb, wr_addr, wr_data, busy}); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
        rst = 1'b0; #(2*Q);
    endtask

    task automatic test_write;
        wbuf = {8'h45, 8'h59, 8'h23};
        model_write(8'h00);
        do_write(8'h00);
        checks++; if (nacks != 0) begin errors++; $display("FAIL write_ack: got %0d nacks want 0", nacks); end
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        checks++; if ({rtc_secd, rtc_mini, rtc_hour} !== {mregs[0], mregs[1], mregs[2]}) begin errors++; $display("FAIL write_rtc: got %h want %h", {rtc_secd, rtc_mini, rtc_hour}, {mregs[0], mregs[1], mregs[2]}); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL write_strobes: got %0d pulses want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL write_strobe%0d: got %h want %h", i, act_q[i], exp_q[i]); end end
        act_q = {}; exp_q = {};
    endtask

    task automatic test_read;
        model_read(8'h01, 2);
        do_read(8'h01, 2);
        checks++; if (nacks != 0) begin errors++; $display("FAIL read_ack: got %0d nacks want 0", nacks); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (rbuf[i] !== ebuf[i]) begin errors++; $display("FAIL read_byte%0d: got %h want %h", i, rbuf[i], ebuf[i]); end
        end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_release: got %b want 1", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_nack: got %b want 0", busy); end
        i2c_stop;
    endtask

    task automatic test_bad_addr;
        logic n;
        i2c_start;
        i2c_wr(8'hA0, n);
        checks++; if (n !== 1'b1) begin errors++; $display("FAIL bad_addr_nack: got %b want 1", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy: got %b want 0", busy); end
        i2c_wr(8'h00, n);
        i2c_wr(8'h77, n);
        i2c_stop;
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL bad_addr_strobes: got %0d pulses want 0", act_q.size()); end
        checks++; if ({rtc_secd, rtc_mini, rtc_hour} !== {mregs[0], mregs[1], mregs[2]}) begin errors++; $display("FAIL bad_addr_rtc: got %h want %h", {rtc_secd, rtc_mini, rtc_hour}, {mregs[0], mregs[1], mregs[2]}); end
        act_q = {};
    endtask

    task automatic test_wrap;
        wbuf = {8'h11, 8'h22};
        model_write(8'h07);
        do_write(8'h07);
        checks++; if (nacks != 0) begin errors++; $display("FAIL wrap_ack: got %0d nacks want 0", nacks); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_strobes: got %0d pulses want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_strobe%0d: got %h want %h", i, act_q[i], exp_q[i]); end end
        act_q = {}; exp_q = {};
        checks++; if (rtc_secd !== mregs[0]) begin errors++; $display("FAIL wrap_reg0: got %h want %h", rtc_secd, mregs[0]); end
        model_read(8'h07, 1);
        do_read(8'h07, 1);
        i2c_stop;
        checks++; if (rbuf[0] !== ebuf[0]) begin errors++; $display("FAIL wrap_reg7: got %h want %h", rbuf[0], ebuf[0]); end
    endtask

    task automatic test_random;
        logic [7:0] p;
        int n;
        for (int t = 0; t < 8; t++) begin
            p = 8'($urandom_range(255));
            n = $urandom_range(1, 4);
            wbuf = {};
            for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(255)));
            model_write(p);
            do_write(p);
            checks++; if (nacks != 0) begin errors++; $display("FAIL rand_wr_ack%0d: got %0d nacks want 0", t, nacks); end
            checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_strobes%0d: got %0d pulses want %0d", t, act_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_strobe%0d_%0d: got %h want %h", t, i, act_q[i], exp_q[i]); end end
            act_q = {}; exp_q = {};
            p = 8'($urandom_range(255));
            n = $urandom_range(1, 4);
            model_read(p, n);
            do_read(p, n);
            i2c_stop;
            checks++; if (nacks != 0) begin errors++; $display("FAIL rand_rd_ack%0d: got %0d nacks want 0", t, nacks); end
            for (int i = 0; i < n; i++) begin
                checks++; if (rbuf[i] !== ebuf[i]) begin errors++; $display("FAIL rand_rd%0d_%0d: got %h want %h", t, i, rbuf[i], ebuf[i]); end
            end
        end
        checks++; if ({rtc_secd, rtc_mini, rtc_hour} !== {mregs[0], mregs[1], mregs[2]}) begin errors++; $display("FAIL rand_rtc: got %h want %h", {rtc_secd, rtc_mini, rtc_hour}, {mregs[0], mregs[1], mregs[2]}); end
    endtask

    task automatic test_reset_midread;
        logic n;
        wbuf = {8'h00};
        model_write(8'h03);
        do_write(8'h03);
        act_q = {}; exp_q = {};
        i2c_start;
        i2c_wr(8'hD0, n);
        i2c_wr(8'h03, n);
        i2c_start;
        i2c_wr(8'hD1, n);
        for (int i = 0; i < 3; i++) begin
            m_sda = 1'b1; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL midread_drive: got %b want 0", sda); end
        rst = 1'b1; #2;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL midread_release: got %b want 1", sda); end
        checks++; if ({rtc_secd, rtc_mini, rtc_hour, wr_stb, wr_addr, wr_data, busy} !== 37'h0) begin errors++; $display("FAIL midread_outs: got %h want 0", {rtc_secd, rtc_mini, rtc_hour, wr_stb, wr_addr, wr_data, busy}); end
        #(Q-2); rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mptr = 3'd0;
        for (int i = 0; i < 6; i++) begin
            m_sda = 1'b1; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
        i2c_stop;
        wbuf = {8'h12, 8'h34};
        model_write(8'h00);
        do_write(8'h00);
        checks++; if (nacks != 0) begin errors++; $display("FAIL post_reset_ack: got %0d nacks want 0", nacks); end
        checks++; if ({rtc_secd, rtc_mini, rtc_hour} !== {mregs[0], mregs[1], mregs[2]}) begin errors++; $display("FAIL post_reset_rtc: got %h want %h", {rtc_secd, rtc_mini, rtc_hour}, {mregs[0], mregs[1], mregs[2]}); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL post_reset_strobes: got %0d pulses want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_reset_strobe%0d: got %h want %h", i, act_q[i], exp_q[i]); end end
        act_q = {}; exp_q = {};
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_bad_addr;
        test_wrap;
        test_random;
        test_reset_midread;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iic_slave_regfile.md
# iic_slave_regfile

I2C target that answers the same two-wire bus our IIC master drives, so the board can emulate an RTC or sensor, and so we can loop the master back against a known device in simulation. It holds an 8-byte register file with a register pointer, and supports master writes (pointer + data) and master reads (data from the pointer). Time registers 0..2 are exposed as BCD outputs for local display logic.

## Interface
- DEV_ADDR, 7'h68: 7-bit target address matched after START.
- clk  input  1  system clock; must be ≥ 20× SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock from master; the target never stretches it.
- sda  inout  1  bus data, open-drain: the block drives only 1'b0 or 1'bz.
- rtc_secd  output  8  register 0, BCD seconds.
- rtc_mini  output  8  register 1, BCD minutes.
- rtc_hour  output  8  register 2, BCD hours.
- wr_stb  output  1  one-clk pulse per data byte written by the master.
- wr_addr  output  3  register index of the current wr_stb.
- wr_data  output  8  byte written; valid with wr_stb.
- busy  output  1  high from an address-matched START until STOP or return to IDLE.

## Operation
- scl and sda pass through a 2-flop synchronizer, then a registered edge detector.
- START is sda falling while scl is high. STOP is sda rising while scl is high.
- The block samples data on scl rising edges, MSB first. It changes its sda drive only on scl falling edges.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: a START goes to ADDR.
- ADDR: shift in 8 bits.
  - If [7:1] == DEV_ADDR, go to ADDR_ACK.
  - Otherwise go to IDLE; sda stays released.
- ADDR_ACK: drive sda low from the falling edge after bit 8 until the next falling edge.
  - R/W = 0: next state is PTR.
  - R/W = 1: next state is RDATA. Load regfile[ptr] into the shifter and drive its MSB on the ACK-ending falling edge.
- PTR: the byte's [2:0] becomes ptr; [7:3] are ignored. ACK in PTR_ACK, then go to WDATA.
- WDATA: the received byte writes regfile[ptr]. Pulse wr_stb with wr_addr = ptr (pre-increment). Advance the pointer per Configuration. ACK in WDATA_ACK, then return to WDATA.
- RDATA: drive 8 bits. After bit 8, release sda and sample the master's bit on the 9th rising edge.
  - ACK (0): advance the pointer and reload the shifter. Go to RDATA.
  - NACK (1): go to IDLE.
- A START in any state (repeated start) goes to ADDR; ptr is retained.
- A STOP in any state goes to IDLE and releases sda.
- The pointer persists across transactions and resets to 0.
- rtc_* outputs are continuous reads of regfile[0..2].

## Timing
- Reset (async): all regfile bytes 8'h00, ptr 0, FSM IDLE, sda released (z), wr_stb 0, wr_addr 0, wr_data 0, busy 0.
- Pin-to-detect latency is 3 clk (2 sync + 1 edge register). sda drive changes 1 clk after the internal falling-edge detect.
- wr_stb goes high 1 clk after the 8th rising edge of a data byte, for exactly 1 clk. regfile and rtc_* update on the same edge.
- busy rises 1 clk after the address-byte 8th-bit detect when the address matches. It falls 1 clk after STOP detect or on NACK.
- Reset asserted mid-byte: sda releases immediately (combinational from rst via the drive flop's async clear). The rest of the byte on the bus is ignored until the next START.
- START and scl-rise detected in the same clk: START wins.

## Configuration
- IIC_SLAVE_AUTOINC_EN defined: ptr increments after every written byte and every ACKed read byte, wrapping 7 → 0.
- IIC_SLAVE_AUTOINC_EN undefined: ptr changes only in PTR. Successive data bytes write or read the same register.

## Test plan
- Write 0xD0, 0x00, 0x45, 0x59, 0x23, STOP → ACK on all 5 bytes; rtc_secd=8'h45, rtc_mini=8'h59, rtc_hour=8'h23; three wr_stb pulses with wr_addr 0, 1, 2; busy low after STOP.
- Following read: 0xD0, 0x01, Sr, 0xD1; master ACKs the first byte and NACKs the second → target returns 0x59 then 0x23; sda released after NACK; FSM IDLE.
- Address 0xA0, 0x00, 0x77 → no ACK on the address byte; no wr_stb; registers unchanged; busy stays 0.
- Wrap with macro: 0xD0, 0x07, 0x11, 0x22 → reg7=0x11, reg0=0x22. Without macro: reg7=0x22, reg0 unchanged.
- Assert rst during bit 4 of a read byte → sda goes z within 1 clk; all outputs at reset values. Next full write transaction completes normally.
- Loopback with the team IIC master reading registers 0..2 at 100 kHz SCL, clk 50 MHz → master receives the written BCD values with correct ACK handling.
